imdct_frame_ctrl: RTL and testbench

Frame sequencer for the IMDCT core with its two-bank RAM wrapper. Accepts one frame command plus a stream of 32-bit input words. Loads the words into the wrapper RAM through the external write port, pulses `start`, and waits for `done`. It then reads the result image back through the external read port and emits it as an output stream with backpressure. It is the only master of the wrapper's `ext_*`/`start`/config pins.

---
 rtl/imdct_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_imdct_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imdct_frame_ctrl.sv
// Frame sequencer for the IMDCT core wrapper. Loads a frame into the two-bank RAM,
// starts the core, waits for done, then streams the result out through a 2-entry FIFO.
module imdct_frame_ctrl #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_tabidx,
  input  logic        cmd_mode,
  input  logic [4:0]  cmd_es,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [31:0] core_ext_din,
  output logic        core_ext_we,
  output logic [9:0]  core_ext_addr,
  output logic        core_start,
  output logic        core_tabidx,
  output logic        core_mode,
  output logic [4:0]  core_es,
  input  logic [31:0] core_dout,
  input  logic        core_done,
  input  logic        core_progress,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned IDX_W  = 11;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WD_W   = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] N_LONG  = IDX_W'(1024);
  localparam logic [IDX_W-1:0] N_SHORT = IDX_W'(128);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              tab_q, tab_d;
  logic              mode_q, mode_d;
  logic [4:0]        es_q, es_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] f0_data_q, f0_data_d;
  logic [DATA_W-1:0] f1_data_q, f1_data_d;
  logic              f0_last_q, f0_last_d;
  logic              f1_last_q, f1_last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0]  n_frame;
  logic [IDX_W-1:0]  last_idx;
  logic [ADDR_W-1:0] map_addr;
  logic              in_hs;
  logic              pop;
  logic              push;
  logic [2:0]        free_slots;
  logic              rd_issue;

  // Handshake decode and read-issue gating; a pop this cycle frees a slot for a new read.
  always_comb begin
    n_frame    = tab_q ? N_LONG : N_SHORT;
    last_idx   = n_frame - IDX_W'(1);
    map_addr   = tab_q ? idx_q[ADDR_W-1:0] : {3'b000, idx_q[6:0]};
    in_hs      = in_valid && (state_q == ST_LOAD);
    pop        = out_valid && out_ready;
    push       = rd_pend_q;
    free_slots = 3'd2 - 3'(cnt_q) + 3'(pop);
    rd_issue   = (state_q == ST_UNLOAD) && !core_progress && (idx_q < n_frame) &&
                 (free_slots > 3'(rd_pend_q));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    err_d     = err_q;
    tab_d     = tab_q;
    mode_d    = mode_q;
    es_d      = es_q;
    rd_pend_d = rd_issue;
    rd_last_d = rd_issue && (idx_q == last_idx);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tab_d   = cmd_tabidx;
          mode_d  = cmd_mode;
          es_d    = cmd_es;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == last_idx) state_d = ST_START;
        end
      end
      ST_START: begin
        idx_d   = '0;
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a simultaneous watchdog expiry
        if (core_done) begin
          state_d = ST_UNLOAD;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_UNLOAD: begin
        if (rd_issue) idx_d = idx_q + IDX_W'(1);
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output FIFO: read data lands one cycle after the address, tagged with its last flag.
  always_comb begin
    f0_data_d = f0_data_q;
    f1_data_d = f1_data_q;
    f0_last_d = f0_last_q;
    f1_last_d = f1_last_q;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q + 2'(push) - 2'(pop);
    if (push && !wr_ptr_q) begin
      f0_data_d = core_dout;
      f0_last_d = rd_last_q;
    end
    if (push && wr_ptr_q) begin
      f1_data_d = core_dout;
      f1_last_d = rd_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      tab_q     <= 1'b0;
      mode_q    <= 1'b0;
      es_q      <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      f0_data_q <= '0;
      f1_data_q <= '0;
      f0_last_q <= 1'b0;
      f1_last_q <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      tab_q     <= tab_d;
      mode_q    <= mode_d;
      es_q      <= es_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      f0_data_q <= f0_data_d;
      f1_data_q <= f1_data_d;
      f0_last_q <= f0_last_d;
      f1_last_q <= f1_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // cmd_ready is held low while reset is applied even though the state decodes as idle.
  assign cmd_ready     = rst_n && (state_q == ST_IDLE);
  assign in_ready      = (state_q == ST_LOAD);
  assign busy          = (state_q != ST_IDLE);
  assign core_start    = (state_q == ST_START);
  assign core_ext_we   = in_hs;
  assign core_ext_din  = in_hs ? in_data : '0;
  assign core_ext_addr = (in_hs || rd_issue) ? map_addr : '0;
  assign core_tabidx   = tab_q;
  assign core_mode     = mode_q;
  assign core_es       = es_q;
  assign err_timeout   = err_q;
  assign out_valid     = (cnt_q != 2'd0);
  assign out_data      = rd_ptr_q ? f1_data_q : f0_data_q;
  assign out_last      = rd_ptr_q ? f1_last_q : f0_last_q;

endmodule

// File: tb/tb_imdct_frame_ctrl.sv
// Scoreboard bench for imdct_frame_ctrl with a loopback core/RAM model.
`timescale 1ns/1ps
module tb_imdct_frame_ctrl;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_tabidx = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [4:0]  cmd_es = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] core_ext_din;
  logic        core_ext_we;
  logic [9:0]  core_ext_addr;
  logic        core_start;
  logic        core_tabidx;
  logic        core_mode;
  logic [4:0]  core_es;
  logic [31:0] core_dout = '0;
  logic        core_done = 1'b0;
  logic        core_progress;
  logic        busy;
  logic        err_timeout;

  always #5 clk = ~clk;

  imdct_frame_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tabidx(cmd_tabidx),
    .cmd_mode(cmd_mode), .cmd_es(cmd_es),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_ext_din(core_ext_din), .core_ext_we(core_ext_we), .core_ext_addr(core_ext_addr),
    .core_start(core_start), .core_tabidx(core_tabidx), .core_mode(core_mode),
    .core_es(core_es), .core_dout(core_dout), .core_done(core_done),
    .core_progress(core_progress), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed { logic [31:0] data; logic last; } out_t;
  typedef struct packed { logic [9:0] addr; logic [31:0] data; } wr_t;

  out_t oq[$];
  wr_t  wq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   ready_pct = 100;
  int   prog_pct = 0;
  int   done_delay = 18;
  int   dcnt = -1;
  logic prog_m = 1'b0;
  logic prog_force = 1'b0;
  bit   no_out = 1'b0;
  logic [6:0] exp_cfg = '0;
  logic [31:0] ram [1024];

  assign core_progress = prog_m | prog_force;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core/RAM model: copies RAM unchanged; reads return garbage while the core owns the RAM.
  always @(posedge clk) begin
    if (!rst_n) begin
      dcnt <= -1;
      prog_m <= 1'b0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        prog_m <= 1'b1;
        dcnt <= done_delay;
      end else if (dcnt > 0) dcnt <= dcnt - 1;
      else if (dcnt == 0) begin
        core_done <= 1'b1;
        prog_m <= 1'b0;
        dcnt <= -1;
      end else if (!busy) prog_m <= 1'b0;
    end
    if (core_ext_we) ram[core_ext_addr] <= core_ext_din;
    core_dout <= core_progress ? 32'hDEAD_BEEF : ram[core_ext_addr];
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready  = (int'($urandom_range(0, 99)) < ready_pct);
    prog_force = (int'($urandom_range(0, 99)) < prog_pct);
  end

  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;
  bit          last_seen = 1'b0;
  out_t        oe;
  wr_t         we;

  // Monitor: output scoreboard, write scoreboard, stability and config-hold checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (last_seen) begin
        chk("busy_after_last", 64'(busy), 64'd0);
        last_seen = 1'b0;
      end
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_last", 64'(out_last), 64'(hold_l));
      end
      if (out_valid && out_ready) begin
        if (oq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_unexpected: actual=%0h required=none", out_data);
        end else begin
          oe = oq.pop_front();
          chk("out_data", 64'(out_data), 64'(oe.data));
          chk("out_last", 64'(out_last), 64'(oe.last));
          if (out_last) last_seen = 1'b1;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (no_out) chk("no_out_valid", 64'(out_valid), 64'd0);
      if (core_ext_we) begin
        if (wq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_unexpected: actual=%0h required=none", core_ext_addr);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", 64'(core_ext_addr), 64'(we.addr));
          chk("wr_data", 64'(core_ext_din), 64'(we.data));
        end
      end
      if (core_start) n_start++;
      chk("cfg_hold", 64'({core_tabidx, core_mode, core_es}), 64'(exp_cfg));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({core_ext_we, core_ext_addr, core_start, core_tabidx, core_mode,
        core_es, err_timeout, busy, out_valid, out_last, in_ready, cmd_ready}), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_ext_din"}, 64'(core_ext_din), 64'd0);
  endtask

  task automatic issue_cmd(input logic tab, input logic mode, input logic [4:0] es);
    int t = 0;
    cmd_tabidx = tab; cmd_mode = mode; cmd_es = es; cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin step(); t++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    exp_cfg = {tab, mode, es};
    cmd_tabidx = ~tab; cmd_mode = ~mode; cmd_es = ~es;
  endtask

  task automatic load(input logic tab, input int nw, input logic [31:0] base, input bit gaps);
    int k = 0;
    int t = 0;
    bit tog = 1'b0;
    while (k < nw && t < 8 * nw + 100) begin
      if (gaps && tog) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data = base + 32'(k);
        if (in_ready) begin
          wq.push_back('{addr: (tab ? 10'(k) : {3'b000, 7'(k)}), data: base + 32'(k)});
          k++;
        end
      end
      tog = !tog;
      step();
      t++;
    end
    in_valid = 1'b0;
    chk("load_count", 64'(k), 64'(nw));
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 20000);
    chk("idle_wait", 64'(busy), 64'd0);
    step();
  endtask

  task automatic run_frame(input logic tab, input logic mode, input logic [4:0] es,
                           input logic [31:0] base, input bit gaps, input bit err_chk);
    int n = tab ? 1024 : 128;
    n_start = 0;
    for (int k = 0; k < n; k++) oq.push_back('{data: base + 32'(k), last: (k == n - 1)});
    issue_cmd(tab, mode, es);
    if (err_chk) begin
      @(negedge clk);
      chk("err_cleared", 64'(err_timeout), 64'd0);
      step();
    end
    load(tab, n, base, gaps);
    wait_idle();
    chk("start_count", 64'(n_start), 64'd1);
    chk("out_remaining", 64'(oq.size()), 64'd0);
    chk("wr_remaining", 64'(wq.size()), 64'd0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst0");
    step(); step();
    rst_n = 1'b1;
    step();

    // short loopback
    run_frame(1'b0, 1'b1, 5'h15, 32'h0000_0000, 1'b0, 1'b0);

    // long frame with backpressure and core RAM ownership stalls
    ready_pct = 30; prog_pct = 20;
    run_frame(1'b1, 1'b0, 5'h0A, 32'hA500_0000, 1'b0, 1'b0);
    ready_pct = 100; prog_pct = 0;
    step(); step();

    // input gaps
    run_frame(1'b0, 1'b0, 5'h07, 32'h0000_1200, 1'b1, 1'b0);

    // watchdog timeout
    done_delay = -1; no_out = 1'b1; n_start = 0;
    issue_cmd(1'b0, 1'b1, 5'h03);
    load(1'b0, 128, 32'h0000_7700, 1'b0);
    t = 0;
    do begin @(negedge clk); t++; end while (!core_start && t < 20);
    chk("tmo_start_seen", 64'(core_start), 64'd1);
    repeat (TMO) @(negedge clk);
    chk("tmo_err_early", 64'(err_timeout), 64'd0);
    chk("tmo_busy_early", 64'(busy), 64'd1);
    @(negedge clk);
    chk("tmo_err_set", 64'(err_timeout), 64'd1);
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_wr_remaining", 64'(wq.size()), 64'd0);
    step(); step();
    no_out = 1'b0; done_delay = 18;
    run_frame(1'b0, 1'b0, 5'h11, 32'h0000_3300, 1'b0, 1'b1);

    // reset in the middle of a load, then a clean frame
    issue_cmd(1'b0, 1'b1, 5'h1F);
    load(1'b0, 50, 32'h0000_5500, 1'b0);
    rst_n = 1'b0;
    exp_cfg = '0;
    @(negedge clk);
    chk_reset("rst_mid");
    wq.delete();
    oq.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    run_frame(1'b0, 1'b0, 5'h0C, 32'h0BAD_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
